// File: rtl/core7_switch_arbiter.sv
// Round-robin arbiter sharing one switch PIO slave among NREQ cores.
// Optional CORE7_SWITCH_ARB_LOCK_EN adds req_lock for back-to-back ownership.
module core7_switch_arbiter #(
    parameter int NREQ = 7,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_addr,
`ifdef CORE7_SWITCH_ARB_LOCK_EN
    input  logic [NREQ-1:0]   req_lock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        s_address,
    input  logic [DW-1:0]     s_readdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] win;
    logic [PW-1:0] hi;
    logic [PW-1:0] lo;
    logic          hi_ok;
    logic          win_ok;
    logic [1:0]    win_addr;
`ifdef CORE7_SWITCH_ARB_LOCK_EN
    logic          locked;
`endif

    // Lowest requester above ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        hi     = '0;
        lo     = '0;
        hi_ok  = 1'b0;
        win_ok = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_ok = 1'b1;
                if (PW'(i) > ptr) begin
                    hi_ok = 1'b1;
                    hi    = PW'(i);
                end else begin
                    lo = PW'(i);
                end
            end
        end
        win = hi_ok ? hi : lo;
`ifdef CORE7_SWITCH_ARB_LOCK_EN
        if (locked) begin
            win    = ptr;
            win_ok = req[ptr];
        end
`endif
    end

    always_comb begin
        win_addr = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win) begin
                win_addr = req_addr[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            s_address <= 2'b00;
            ptr       <= PW'(NREQ - 1);
            cur       <= '0;
`ifdef CORE7_SWITCH_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            case (state)
                IDLE: begin
                    if (win_ok) begin
                        cur       <= win;
                        s_address <= win_addr;
                        gnt       <= NREQ'(1) << win;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rdata     <= s_readdata;
                    rvalid    <= NREQ'(1) << cur;
                    ptr       <= cur;
                    s_address <= 2'b00;
`ifdef CORE7_SWITCH_ARB_LOCK_EN
                    locked    <= req_lock[cur];
`endif
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core7_switch_arbiter.sv
// Directed self-checking bench for core7_switch_arbiter.
// Lock scenario runs only when CORE7_SWITCH_ARB_LOCK_EN is defined.
module tb_core7_switch_arbiter;

    logic        clk;
    logic        reset_n;
    logic [6:0]  req;
    logic [13:0] req_addr;
    logic [6:0]  req_lock;
    logic [6:0]  gnt;
    logic [6:0]  rvalid;
    logic [31:0] rdata;
    logic [1:0]  s_address;
    logic [31:0] s_readdata;
    logic [31:0] sw_val;

    int n_cmp;
    int n_err;

    core7_switch_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_addr   (req_addr),
`ifdef CORE7_SWITCH_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .s_address  (s_address),
        .s_readdata (s_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave registers the read one clock after s_address; nonzero addr reads 0.
    always @(posedge clk) begin
        s_readdata <= (s_address == 2'd0) ? sw_val : 32'd0;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = '0;
        #1;
        n_cmp++;
        if (gnt !== 7'd0) begin
            n_err++;
            $display("FAIL reset_gnt got %b want %b", gnt, 7'd0);
        end
        n_cmp++;
        if (rvalid !== 7'd0) begin
            n_err++;
            $display("FAIL reset_rvalid got %b want %b", rvalid, 7'd0);
        end
        n_cmp++;
        if (s_address !== 2'd0) begin
            n_err++;
            $display("FAIL reset_saddr got %0d want 0", s_address);
        end
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rdata got %h want 0", rdata);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 7'd0) begin
            n_err++;
            $display("FAIL idle_gnt got %b want 0", gnt);
        end
    endtask

    task automatic test_single();
        sw_val   = 32'h0002_A5A5;
        req_addr = '0;
        req      = 7'b0000001;
        tick();
        n_cmp++;
        if (gnt !== 7'b0000001) begin
            n_err++;
            $display("FAIL single_gnt got %b want 0000001", gnt);
        end
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== 7'd0 || rvalid !== 7'd0) begin
            n_err++;
            $display("FAIL single_wait got g=%b v=%b want 0/0", gnt, rvalid);
        end
        tick();
        n_cmp++;
        if (rvalid !== 7'b0000001) begin
            n_err++;
            $display("FAIL single_rvalid got %b want 0000001", rvalid);
        end
        n_cmp++;
        if (rdata !== 32'h0002_A5A5) begin
            n_err++;
            $display("FAIL single_rdata got %h want 0002a5a5", rdata);
        end
        tick();
        n_cmp++;
        if (rvalid !== 7'd0 || rdata !== 32'h0002_A5A5) begin
            n_err++;
            $display("FAIL single_hold got v=%b d=%h want 0/0002a5a5",
                     rvalid, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] exp;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 7'b1111111;
        for (int k = 0; k < 8; k++) begin
            exp = 7'd1 << (k % 7);
            tick();
            n_cmp++;
            if (gnt !== exp) begin
                n_err++;
                $display("FAIL rr_gnt%0d got %b want %b", k, gnt, exp);
            end
            sw_val = 32'hC0DE_0000 | k;
            if (k == 7) req = '0;
            tick();
            n_cmp++;
            if (gnt !== 7'd0) begin
                n_err++;
                $display("FAIL rr_gap%0d got %b want 0", k, gnt);
            end
            tick();
            n_cmp++;
            if (rvalid !== exp || rdata !== (32'hC0DE_0000 | k)) begin
                n_err++;
                $display("FAIL rr_rvalid%0d got %b/%h want %b/%h",
                         k, rvalid, rdata, exp, 32'hC0DE_0000 | k);
            end
        end
    endtask

    task automatic test_wrap();
        req = 7'b0001000;
        tick();
        n_cmp++;
        if (gnt !== 7'b0001000) begin
            n_err++;
            $display("FAIL wrap_gnt3 got %b want 0001000", gnt);
        end
        req = '0;
        tick();
        tick();
        req = 7'b0001010;
        tick();
        n_cmp++;
        if (gnt !== 7'b0000010) begin
            n_err++;
            $display("FAIL wrap_gnt1 got %b want 0000010", gnt);
        end
        req = 7'b0001000;
        tick();
        tick();
        n_cmp++;
        if (rvalid !== 7'b0000010) begin
            n_err++;
            $display("FAIL wrap_rv1 got %b want 0000010", rvalid);
        end
        tick();
        n_cmp++;
        if (gnt !== 7'b0001000) begin
            n_err++;
            $display("FAIL wrap_gnt3b got %b want 0001000", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_addr();
        sw_val   = 32'hFFFF_FFFF;
        req_addr = 14'h0010;
        req      = 7'b0000100;
        tick();
        n_cmp++;
        if (gnt !== 7'b0000100 || s_address !== 2'd1) begin
            n_err++;
            $display("FAIL addr_gnt got %b/%0d want 0000100/1", gnt, s_address);
        end
        req = '0;
        tick();
        n_cmp++;
        if (s_address !== 2'd1) begin
            n_err++;
            $display("FAIL addr_hold got %0d want 1", s_address);
        end
        tick();
        n_cmp++;
        if (rvalid !== 7'b0000100 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL addr_rd got %b/%h want 0000100/0", rvalid, rdata);
        end
        req_addr = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        sw_val = 32'h1357_9BDF;
        req    = 7'b0010000;
        tick();
        n_cmp++;
        if (gnt !== 7'b0010000) begin
            n_err++;
            $display("FAIL rmid_gnt got %b want 0010000", gnt);
        end
        #2;
        reset_n = 1'b0;
        req     = '0;
        #1;
        n_cmp++;
        if (gnt !== 7'd0 || rvalid !== 7'd0 || s_address !== 2'd0 ||
            rdata !== 32'd0) begin
            n_err++;
            $display("FAIL rmid_async got %b/%b/%0d/%h want all 0",
                     gnt, rvalid, s_address, rdata);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (rvalid !== 7'd0 || gnt !== 7'd0) begin
            n_err++;
            $display("FAIL rmid_norv got %b/%b want 0/0", rvalid, gnt);
        end
        req = 7'b0010000;
        tick();
        n_cmp++;
        if (gnt !== 7'b0010000) begin
            n_err++;
            $display("FAIL rmid_regnt got %b want 0010000", gnt);
        end
        req = '0;
        tick();
        tick();
        n_cmp++;
        if (rvalid !== 7'b0010000 || rdata !== 32'h1357_9BDF) begin
            n_err++;
            $display("FAIL rmid_rv got %b/%h want 0010000/13579bdf",
                     rvalid, rdata);
        end
    endtask

`ifdef CORE7_SWITCH_ARB_LOCK_EN
    task automatic test_lock();
        req_lock = 7'b0100000;
        req      = 7'b0100001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (gnt !== 7'b0100000) begin
                n_err++;
                $display("FAIL lock_gnt%0d got %b want 0100000", k, gnt);
            end
            if (k == 2) begin
                req_lock = '0;
                req      = 7'b0000001;
            end
            tick();
            tick();
        end
        tick();
        n_cmp++;
        if (gnt !== 7'b0000001) begin
            n_err++;
            $display("FAIL lock_release got %b want 0000001", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        req_lock = '0;
        sw_val   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_addr();
        test_reset_mid();
`ifdef CORE7_SWITCH_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
